imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time programming controller for the 64-entry, 32-bit instruction memory; an alternative to loading the image from a file at elaboration.
- Accepts a byte stream over a valid/ready handshake and assembles it into little-endian 32-bit words.
- Drives the memory write port with word-aligned byte addresses.
- Holds the core in reset while loading, then releases it.
- Sits between the external programming link and the instruction memory write port.

Parameters:
- MEM_DEPTH, 64: number of 32-bit words in instruction memory.
- ADDR_W, 6: word-index width; must satisfy 2^ADDR_W >= MEM_DEPTH.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- rst_n, input, 1: synchronous active-low reset.
- start, input, 1: single-cycle pulse that begins a load; honoured only in IDLE or DONE.
- num_words, input, ADDR_W+1: number of words to load; sampled on an accepted start.
- abort, input, 1: cancels an in-progress load.
- byte_valid, input, 1: byte_data is valid.
- byte_data, input, 8: stream byte.
- byte_ready, output, 1: loader can accept a byte.
- mem_we, output, 1: instruction memory write enable.
- mem_addr, output, 32: byte address; bits [1:0] are always 0.
- mem_wdata, output, 32: write data.
- cpu_hold, output, 1: active-high; the core must be held in reset while this is 1.
- busy, output, 1: a load is in progress.
- done, output, 1: sticky; last load completed.
- err, output, 1: sticky; last start was rejected.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state goes to IDLE.
  - All outputs go to 0, including mem_addr and mem_wdata.
  - Word index and byte counter are cleared; the partial word is discarded.
  - Reset mid-load behaves the same way: no further writes occur.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE / DONE, start=1:
  - If num_words==0 or num_words>MEM_DEPTH: err<=1, done<=0, stay in the current state.
  - Otherwise: latch num_words, clear the word index and byte counter, err<=0, done<=0, go to COLLECT.
- COLLECT:
  - byte_ready=1. A byte is accepted on a cycle where byte_valid && byte_ready.
  - Byte k (k=0..3) is stored in bits [8k+7:8k].
  - When the 4th byte is accepted, go to WRITE on the next cycle.
- WRITE:
  - byte_ready=0; mem_we=1 for exactly one cycle.
  - mem_addr = {word_index, 2'b00} zero-extended to 32 bits; mem_wdata = the assembled word.
  - Then increment word_index.
  - If word_index+1 == latched num_words: go to DONE and set done<=1.
  - Otherwise go to COLLECT.
- Latency and throughput:
  - Acceptance of the 4th byte in cycle N gives mem_we=1 in cycle N+1.
  - Minimum 5 cycles per word.
- cpu_hold = busy = 1 in COLLECT and WRITE, 0 otherwise.
- mem_we is 0 in every state except WRITE.
- mem_addr and mem_wdata hold their last values outside WRITE.
- abort=1 in COLLECT or WRITE:
  - Go to IDLE next cycle; the partial word is discarded.
  - No write occurs in that cycle, even from WRITE; abort has priority over mem_we.
  - done<=0, err unchanged.
  - abort in IDLE or DONE has no effect.
- start during COLLECT or WRITE is ignored.
- If start and abort are asserted together in COLLECT or WRITE, abort wins.
- byte_valid while byte_ready=0 is not consumed; the source must hold the byte.

Test Plan:
- Reset, then start with num_words=2 and stream bytes 13,00,00,00,93,00,10,00 back-to-back → writes 0x00000013 to addr 0x0 and 0x00100093 to addr 0x4, each mem_we exactly 1 cycle; done=1; cpu_hold low after the 2nd write.
- byte_valid toggled 1-0-1 with gaps during one word AA,BB,CC,DD → single write of 0xDDCCBBAA; mem_we one cycle after the 4th accepted byte; gaps consume nothing.
- start with num_words=0 → err=1, state IDLE, no write; then num_words=65 → err=1; then num_words=1 → err=0, busy=1.
- Load of 64 words with data equal to the index → last write at addr 0xFC with data 0x3F; done=1; exactly 64 mem_we pulses.
- abort after 2 bytes of word 3, then restart with num_words=1 → no write for the aborted word; new write at addr 0x0.
- rst_n=0 for one cycle during WRITE → mem_we=0 that cycle; all outputs 0 and state IDLE next cycle.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles a little-endian byte stream into
// 32-bit words, writes them to instruction memory and holds the core in reset meanwhile.
module imem_loader #(
  parameter int MEM_DEPTH = 64,
  parameter int ADDR_W    = 6
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   num_words_i,
  input  logic              abort_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              cpu_hold_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  // state   | meaning
  // IDLE    | no load since reset or last abort
  // COLLECT | accepting bytes of the current word
  // WRITE   | one-cycle memory write of the assembled word
  // DONE    | last load completed
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] ONE       = 1;
  localparam logic [ADDR_W:0] MAX_WORDS = MEM_DEPTH;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   word_idx_q, word_idx_d;
  logic [ADDR_W:0]   num_q, num_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       word_q, word_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   idx_inc;

  assign idx_inc = word_idx_q + ONE;

  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    num_d        = num_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    done_d       = done_q;
    err_d        = err_q;
    byte_ready_o = 1'b0;
    mem_we_o     = 1'b0;
    busy_o       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          done_d = 1'b0;
          if ((num_words_i == '0) || (num_words_i > MAX_WORDS)) begin
            err_d = 1'b1;
          end else begin
            err_d      = 1'b0;
            num_d      = num_words_i;
            word_idx_d = '0;
            byte_cnt_d = '0;
            state_d    = S_COLLECT;
          end
        end
      end

      S_COLLECT: begin
        busy_o       = 1'b1;
        byte_ready_o = 1'b1;
        if (abort_i) begin
          byte_cnt_d = '0;
          done_d     = 1'b0;
          state_d    = S_IDLE;
        end else if (byte_valid_i) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: word_d[7:0]   = byte_data_i;
            2'd1: word_d[15:8]  = byte_data_i;
            2'd2: word_d[23:16] = byte_data_i;
            default: begin
              // Latch the write port now so address/data are stable through WRITE and after it.
              wdata_d = {byte_data_i, word_q};
              addr_d  = {{(30-ADDR_W){1'b0}}, word_idx_q[ADDR_W-1:0], 2'b00};
              state_d = S_WRITE;
            end
          endcase
        end
      end

      S_WRITE: begin
        busy_o = 1'b1;
        if (abort_i) begin
          byte_cnt_d = '0;
          done_d     = 1'b0;
          state_d    = S_IDLE;
        end else begin
          mem_we_o   = rst_n_i;
          word_idx_d = idx_inc;
          if (idx_inc == num_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      word_idx_q <= '0;
      num_q      <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      num_q      <= num_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign cpu_hold_o  = busy_o;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: loads, gapped streams, rejected starts, full-depth load,
// abort and reset during a write.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [6:0]  num_words;
  logic        abort;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  int          wr_count = 0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  imem_loader #(.MEM_DEPTH(64), .ADDR_W(6)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .num_words_i  (num_words),
    .abort_i      (abort),
    .byte_valid_i (byte_valid),
    .byte_data_i  (byte_data),
    .byte_ready_o (byte_ready),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .cpu_hold_o   (cpu_hold),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      wr_count     <= wr_count + 1;
      last_wr_addr <= mem_addr;
      last_wr_data <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [6:0] n);
    start     = 1'b1;
    num_words = n;
    next_cycle();
    start     = 1'b0;
  endtask

  // Presents one byte and returns one step after the edge where it was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    #1;
    while (byte_ready !== 1'b1 && n < 20) begin
      next_cycle();
      n++;
    end
    if (n >= 20) check("ready_timeout", 32'(byte_ready), 32'd1);
    next_cycle();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  initial begin
    int wr_base;
    rst_n = 1'b0; start = 1'b0; num_words = '0; abort = 1'b0;
    byte_valid = 1'b0; byte_data = '0;
    repeat (3) next_cycle();
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_hold",  32'(cpu_hold), 32'd0);
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_we",    32'(mem_we), 32'd0);
    check("rst_addr",  mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    rst_n = 1'b1;
    next_cycle();

    // Two-word load, bytes back to back.
    start_load(7'd2);
    check("t1_busy",  32'(busy), 32'd1);
    check("t1_hold",  32'(cpu_hold), 32'd1);
    check("t1_ready", 32'(byte_ready), 32'd1);
    send_word(32'h0000_0013);
    check("t1_we0",    32'(mem_we), 32'd1);
    check("t1_addr0",  mem_addr, 32'h0);
    check("t1_data0",  mem_wdata, 32'h0000_0013);
    check("t1_rdy_wr", 32'(byte_ready), 32'd0);
    next_cycle();
    check("t1_we_one_cycle", 32'(mem_we), 32'd0);
    send_word(32'h0010_0093);
    check("t1_we1",   32'(mem_we), 32'd1);
    check("t1_addr1", mem_addr, 32'h4);
    check("t1_data1", mem_wdata, 32'h0010_0093);
    next_cycle();
    check("t1_done",  32'(done), 32'd1);
    check("t1_hold_off", 32'(cpu_hold), 32'd0);
    check("t1_busy_off", 32'(busy), 32'd0);
    check("t1_we_off", 32'(mem_we), 32'd0);
    check("t1_addr_hold", mem_addr, 32'h4);
    check("t1_wrcount", 32'(wr_count), 32'd2);

    // Gapped byte_valid within one word.
    start_load(7'd1);
    check("t2_done_clr", 32'(done), 32'd0);
    send_byte(8'hAA);
    next_cycle(); next_cycle();
    send_byte(8'hBB);
    next_cycle();
    send_byte(8'hCC);
    next_cycle(); next_cycle(); next_cycle();
    check("t2_no_early_write", 32'(wr_count), 32'd2);
    send_byte(8'hDD);
    check("t2_we",   32'(mem_we), 32'd1);
    check("t2_addr", mem_addr, 32'h0);
    check("t2_data", mem_wdata, 32'hDDCC_BBAA);
    next_cycle();
    check("t2_wrcount", 32'(wr_count), 32'd3);
    check("t2_done", 32'(done), 32'd1);

    // Rejected starts, then an accepted one.
    start_load(7'd0);
    check("t3_err0",  32'(err), 32'd1);
    check("t3_done0", 32'(done), 32'd0);
    check("t3_busy0", 32'(busy), 32'd0);
    start_load(7'd65);
    check("t3_err65",  32'(err), 32'd1);
    check("t3_busy65", 32'(busy), 32'd0);
    start_load(7'd1);
    check("t3_err_clr", 32'(err), 32'd0);
    check("t3_busy1",   32'(busy), 32'd1);
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    check("t3_abort_idle", 32'(busy), 32'd0);
    check("t3_wrcount", 32'(wr_count), 32'd3);

    // Full-depth load, data equal to the word index.
    wr_base = wr_count;
    start_load(7'd64);
    for (int i = 0; i < 64; i++) send_word(32'(i));
    next_cycle();
    check("t4_pulses", 32'(wr_count - wr_base), 32'd64);
    check("t4_last_addr", last_wr_addr, 32'h0000_00FC);
    check("t4_last_data", last_wr_data, 32'h0000_003F);
    check("t4_done", 32'(done), 32'd1);
    check("t4_hold", 32'(cpu_hold), 32'd0);

    // Abort after two bytes of word 3, then restart.
    wr_base = wr_count;
    start_load(7'd4);
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    send_word(32'h3333_3333);
    send_byte(8'h44);
    send_byte(8'h44);
    abort = 1'b1;
    #1;
    check("t5_abort_we", 32'(mem_we), 32'd0);
    next_cycle();
    abort = 1'b0;
    check("t5_idle",  32'(busy), 32'd0);
    check("t5_done",  32'(done), 32'd0);
    next_cycle();
    check("t5_writes", 32'(wr_count - wr_base), 32'd3);
    start_load(7'd1);
    send_word(32'hCAFE_F00D);
    check("t5_new_addr", mem_addr, 32'h0);
    check("t5_new_data", mem_wdata, 32'hCAFE_F00D);
    check("t5_new_we",   32'(mem_we), 32'd1);

    // Abort in WRITE suppresses the write.
    next_cycle();
    wr_base = wr_count;
    start_load(7'd1);
    send_word(32'h5555_AAAA);
    abort = 1'b1;
    #1;
    check("t5w_we", 32'(mem_we), 32'd0);
    next_cycle();
    abort = 1'b0;
    check("t5w_idle",   32'(busy), 32'd0);
    check("t5w_done",   32'(done), 32'd0);
    check("t5w_writes", 32'(wr_count - wr_base), 32'd0);

    // Reset asserted during WRITE.
    wr_base = wr_count;
    start_load(7'd1);
    send_word(32'h7777_8888);
    rst_n = 1'b0;
    #1;
    check("t6_we", 32'(mem_we), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    #1;
    check("t6_busy",  32'(busy), 32'd0);
    check("t6_ready", 32'(byte_ready), 32'd0);
    check("t6_addr",  mem_addr, 32'h0);
    check("t6_wdata", mem_wdata, 32'h0);
    check("t6_done",  32'(done), 32'd0);
    check("t6_err",   32'(err), 32'd0);
    check("t6_writes", 32'(wr_count - wr_base), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
